// File: rtl/bram_stream_pkg.sv
// Shared types and width helpers for the BRAM stream reader.
// Optional looping is enabled by defining BRAM_STREAM_LOOP_EN.
package bram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  // Address width for a given BRAM depth, never below one bit.
  function automatic int unsigned adr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Burst length field needs one extra bit so a full-depth burst fits.
  function automatic int unsigned len_width(input int unsigned depth);
    return adr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// Request, BRAM and stream signals of the BRAM stream reader.
// LOOP exists only when BRAM_STREAM_LOOP_EN is defined.
interface bram_stream_reader_if
  import bram_stream_pkg::*;
#(
  parameter int unsigned BITWIDTH = 12,
  parameter int unsigned RAMWIDTH = 32
) ();

  localparam int unsigned AW = adr_width(RAMWIDTH);
  localparam int unsigned LW = len_width(RAMWIDTH);

  logic                START;
  logic [AW-1:0]       ADR_START;
  logic [LW-1:0]       LENGTH;
`ifdef BRAM_STREAM_LOOP_EN
  logic                LOOP;
`endif
  logic                BRAM_EN;
  logic                BRAM_WE;
  logic [AW-1:0]       BRAM_ADR;
  logic [BITWIDTH-1:0] BRAM_DOUT;
  logic [BITWIDTH-1:0] DOUT;
  logic                DOUT_VALID;
  logic                DOUT_READY;
  logic                BUSY;
  logic                DONE;

  modport master (
`ifdef BRAM_STREAM_LOOP_EN
    input  LOOP,
`endif
    input  START, ADR_START, LENGTH, BRAM_DOUT, DOUT_READY,
    output BRAM_EN, BRAM_WE, BRAM_ADR, DOUT, DOUT_VALID, BUSY, DONE
  );

  modport slave (
`ifdef BRAM_STREAM_LOOP_EN
    output LOOP,
`endif
    output START, ADR_START, LENGTH, BRAM_DOUT, DOUT_READY,
    input  BRAM_EN, BRAM_WE, BRAM_ADR, DOUT, DOUT_VALID, BUSY, DONE
  );

endinterface

// File: rtl/bram_adr_counter.sv
// BRAM read address register: load, increment, wrap at RAMWIDTH-1.
module bram_adr_counter
  import bram_stream_pkg::*;
#(
  parameter  int unsigned RAMWIDTH = 32,
  localparam int unsigned AW       = adr_width(RAMWIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] load_adr,
  output logic [AW-1:0] adr
);

  logic [AW-1:0] adr_q, adr_d;

  // Load wins over increment so a loop restart lands exactly on the start address.
  always_comb begin
    adr_d = adr_q;
    if (load) begin
      adr_d = load_adr;
    end else if (inc) begin
      adr_d = (adr_q == AW'(RAMWIDTH - 1)) ? '0 : adr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adr_q <= '0;
    end else begin
      adr_q <= adr_d;
    end
  end

  assign adr = adr_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of words from a single-port BRAM and streams them out valid/ready.
// Defining BRAM_STREAM_LOOP_EN adds the LOOP input for continuous repeat of the burst.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int unsigned BITWIDTH = 12,
  parameter int unsigned RAMWIDTH = 32
) (
  input logic                  CLK,
  input logic                  nRST,
  bram_stream_reader_if.master bus
);

  localparam int unsigned AW = adr_width(RAMWIDTH);
  localparam int unsigned LW = len_width(RAMWIDTH);
  localparam logic [LW-1:0] LEN_MAX = LW'(RAMWIDTH);

  state_e              state_q, state_d;
  logic [BITWIDTH-1:0] dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bram_en_q;
  logic [LW-1:0]       count_q, count_d;
  logic [LW-1:0]       len_q, len_d;
  logic [AW-1:0]       start_adr_q, start_adr_d;

  logic [LW-1:0]       len_sat;
  logic                loop_en;
  logic                load_word;
  logic                last_word;
  logic                adr_load;
  logic                adr_inc;
  logic [AW-1:0]       adr_load_val;
  logic [AW-1:0]       bram_adr;

  assign len_sat = (bus.LENGTH > LEN_MAX) ? LEN_MAX : bus.LENGTH;

`ifdef BRAM_STREAM_LOOP_EN
  assign loop_en = bus.LOOP;
`else
  assign loop_en = 1'b0;
`endif

  bram_adr_counter #(
    .RAMWIDTH (RAMWIDTH)
  ) u_adr_counter (
    .clk      (CLK),
    .rst_n    (nRST),
    .load     (adr_load),
    .inc      (adr_inc),
    .load_adr (adr_load_val),
    .adr      (bram_adr)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    count_d      = count_q;
    len_d        = len_q;
    start_adr_d  = start_adr_q;
    adr_load     = 1'b0;
    adr_inc      = 1'b0;
    adr_load_val = start_adr_q;
    load_word    = (state_q == STREAM) && (!dout_valid_q || bus.DOUT_READY);
    last_word    = load_word && (count_q == LW'(1));

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          if (len_sat != '0) begin
            state_d      = STREAM;
            busy_d       = 1'b1;
            count_d      = len_sat;
            len_d        = len_sat;
            start_adr_d  = bus.ADR_START;
            adr_load     = 1'b1;
            adr_load_val = bus.ADR_START;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      STREAM: begin
        if (load_word) begin
          dout_d       = bus.BRAM_DOUT;
          dout_valid_d = 1'b1;
          adr_inc      = 1'b1;
          count_d      = count_q - LW'(1);
          // Looping restarts the pass seamlessly; otherwise wait for the final handshake.
          if (last_word) begin
            if (loop_en) begin
              adr_load = 1'b1;
              count_d  = len_q;
              done_d   = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end
        end
      end

      DRAIN: begin
        if (dout_valid_q && bus.DOUT_READY) begin
          dout_valid_d = 1'b0;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // BRAM_EN drops only in reset, which intentionally reinitialises the BRAM contents.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bram_en_q    <= 1'b0;
      count_q      <= '0;
      len_q        <= '0;
      start_adr_q  <= '0;
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      bram_en_q    <= 1'b1;
      count_q      <= count_d;
      len_q        <= len_d;
      start_adr_q  <= start_adr_d;
    end
  end

  assign bus.BRAM_EN    = bram_en_q;
  assign bus.BRAM_WE    = 1'b0;
  assign bus.BRAM_ADR   = bram_adr;
  assign bus.DOUT       = dout_q;
  assign bus.DOUT_VALID = dout_valid_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter BITWIDTH, default 12, meaning data word width (matches the single-port BRAM).
REQ-002 SHALL have parameter RAMWIDTH, default 32, meaning BRAM depth in words; AW = $clog2(RAMWIDTH).
REQ-003 SHALL have port CLK  input  1  single clock, all logic on posedge.
REQ-004 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port START  input  1  single-cycle request to begin a read burst.
REQ-006 SHALL have port ADR_START  input  AW  first BRAM address of the burst.
REQ-007 SHALL have port LENGTH  input  AW+1  number of words in the burst.
REQ-008 SHALL have port BRAM_EN  output  1  drives the BRAM EN.
REQ-009 SHALL have port BRAM_WE  output  1  drives the BRAM WE; constant 0.
REQ-010 SHALL have port BRAM_ADR  output  AW  drives the BRAM ADR.
REQ-011 SHALL have port BRAM_DOUT  input  BITWIDTH  BRAM read data, combinational from BRAM_ADR.
REQ-012 SHALL have port DOUT  output  BITWIDTH  stream data.
REQ-013 SHALL have port DOUT_VALID  output  1  stream valid.
REQ-014 SHALL have port DOUT_READY  input  1  downstream ready.
REQ-015 SHALL have port BUSY  output  1  high from the cycle after an accepted START until the cycle DONE pulses.
REQ-016 SHALL have port DONE  output  1  one-cycle pulse at burst completion.

Function
REQ-017 SHALL implement states IDLE, STREAM, DRAIN.
REQ-018 IDLE: START=1 with LENGTH!=0 SHALL latch ADR_START and the count, then go to STREAM; START with LENGTH=0 SHALL stay in IDLE and pulse DONE in the next cycle.
REQ-019 LENGTH > RAMWIDTH SHALL saturate to RAMWIDTH.
REQ-020 START in STREAM or DRAIN SHALL be ignored.
REQ-021 STREAM: when DOUT_VALID=0 or DOUT_READY=1, SHALL load DOUT<=BRAM_DOUT, set DOUT_VALID=1, advance BRAM_ADR, and decrement the remaining count.
REQ-022 Address advance SHALL wrap from RAMWIDTH-1 to 0.
REQ-023 After the last word is loaded, SHALL go to DRAIN.
REQ-024 DRAIN: on DOUT_VALID && DOUT_READY, SHALL clear DOUT_VALID, pulse DONE, and return to IDLE.
REQ-025 DOUT and DOUT_VALID SHALL hold stable while DOUT_VALID=1 and DOUT_READY=0.
REQ-026 Latency: START accepted in cycle 0 SHALL give DOUT_VALID=1 in cycle 2 with DOUT=mem[ADR_START].
REQ-027 Throughput SHALL be one word per cycle while DOUT_READY=1.
REQ-028 BRAM_EN SHALL be 1 in every state outside reset, because EN=0 clears or reloads the BRAM array.
REQ-029 BRAM_WE SHALL be constant 0.

Reset
REQ-030 While nRST=0 at posedge, SHALL force: state=IDLE, BRAM_EN=0 (this deliberately reinitialises the BRAM), BRAM_ADR=0, DOUT=0, DOUT_VALID=0, BUSY=0, DONE=0, count=0.
REQ-031 Reset mid-burst SHALL abort the burst without a DONE pulse.
REQ-032 The first START is accepted in the first cycle after nRST returns high.

Configuration
REQ-033 Macro BRAM_STREAM_LOOP_EN, when defined, SHALL add input LOOP (1 bit).
REQ-034 With BRAM_STREAM_LOOP_EN defined, LOOP=1 at the cycle the last word is loaded SHALL reload the address from the latched start and the count from the latched length, stay in STREAM with no gap, and pulse DONE.
REQ-035 With BRAM_STREAM_LOOP_EN defined, LOOP=0 at the cycle the last word is loaded SHALL follow REQ-023.
REQ-036 Without BRAM_STREAM_LOOP_EN, the LOOP port SHALL be absent and every burst SHALL be single-pass.

Structure
REQ-037 Package bram_stream_pkg SHALL hold the state enum (IDLE, STREAM, DRAIN) and the address-width/saturation helper constants.
REQ-038 Sub-module bram_adr_counter (load, increment, wrap at RAMWIDTH-1) SHALL be the one natural sub-module.
REQ-039 The bench SHALL pair the block with the single-port BRAM loaded with mem[i]=i+0x100.

Verification
REQ-040 Burst: ADR_START=4, LENGTH=3, READY=1 -> DOUT 0x104, 0x105, 0x106 on consecutive cycles from cycle 2; DONE one cycle after the last handshake.
REQ-041 Wrap: ADR_START=30, LENGTH=4 -> DOUT 0x11E, 0x11F, 0x100, 0x101.
REQ-042 Backpressure: READY=0 for 3 cycles mid-burst -> DOUT held stable; no word lost or duplicated.
REQ-043 Edge cases: LENGTH=0 -> DONE next cycle with no VALID; LENGTH=40 -> exactly 32 words; START during BUSY -> ignored.
REQ-044 Reset: nRST=0 mid-burst -> all outputs zero next cycle, no DONE, BRAM_EN=0 for the reset duration.
REQ-045 BRAM_STREAM_LOOP_EN defined: LOOP=1, ADR_START=0, LENGTH=2 -> repeating 0x100, 0x101 with DONE every pass; LOOP=0 -> stops after the current pass.
